// File: rtl/uart_tx.sv
`timescale 1ns / 1ps
// uart_tx: 8N1 UART transmitter with a one-entry holding buffer.
// Accepts bytes on a valid/ready handshake and serialises them onto uart_txd:
// start bit, 8 data bits LSB first, one stop bit. A byte queued during a frame
// follows the current stop bit with no idle gap.
//
// Ports:
//   sys_clk        system clock, rising edge
//   sys_rst_n      asynchronous reset, active HIGH (name kept for consistency)
//   uart_tx_valid  uart_tx_data holds a byte to send
//   uart_tx_data   byte to send, sampled on handshake only
//   uart_tx_ready  holding buffer empty, a byte can be accepted
//   uart_txd       serial line, idle high, registered
//   uart_tx_busy   a frame is in progress
//   tx_done        one-cycle pulse in the last clock of each stop bit
module uart_tx #(
  parameter int unsigned BPS         = 9600,
  parameter int unsigned SYS_CLK_FRE = 50_000_000,
  parameter int unsigned BPS_CNT     = SYS_CLK_FRE / BPS
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_tx_valid,
  input  logic [7:0] uart_tx_data,
  output logic       uart_tx_ready,
  output logic       uart_txd,
  output logic       uart_tx_busy,
  output logic       tx_done
);

  localparam logic [15:0] LastCnt = 16'(BPS_CNT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  buf_q, buf_d;
  logic        buf_full_q, buf_full_d;
  logic        txd_q, txd_d;
  logic        bit_end;
  logic        accept;
  logic        load;

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    load       = 1'b0;
    tx_done    = 1'b0;
    bit_end    = (clk_cnt_q == LastCnt);
    accept     = uart_tx_valid && !buf_full_q;

    if (state_q != StIdle) begin
      clk_cnt_d = bit_end ? 16'd0 : clk_cnt_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        clk_cnt_d = 16'd0;
        if (buf_full_q) begin
          load    = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_cnt_d = 3'd0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          tx_done = 1'b1;
          // Chain straight into the next frame when a byte is already waiting.
          if (buf_full_q) begin
            load    = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      shift_d = buf_q;
    end

    // accept and load are exclusive: accept needs an empty buffer, load a full one.
    buf_d      = accept ? uart_tx_data : buf_q;
    buf_full_d = accept ? 1'b1 : (load ? 1'b0 : buf_full_q);

    // Line level follows the next state so uart_txd stays a plain register.
    unique case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state_q    <= StIdle;
      clk_cnt_q  <= 16'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      buf_q      <= 8'd0;
      buf_full_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      txd_q      <= txd_d;
    end
  end

  assign uart_tx_ready = ~buf_full_q;
  assign uart_txd      = txd_q;
  assign uart_tx_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns / 1ps
// Bench for uart_tx at BPS_CNT = 10. A line decoder acts as the receiver and
// checks each decoded byte against a scoreboard filled at handshake time.
module tb_uart_tx;

  localparam int unsigned SysClkFre = 1000;
  localparam int unsigned Bps       = 100;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       uart_tx_valid = 1'b0;
  logic [7:0] uart_tx_data = 8'd0;
  logic       uart_tx_ready;
  logic       uart_txd;
  logic       uart_tx_busy;
  logic       tx_done;

  uart_tx #(
    .BPS         (Bps),
    .SYS_CLK_FRE (SysClkFre)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_ready (uart_tx_ready),
    .uart_txd      (uart_txd),
    .uart_tx_busy  (uart_tx_busy),
    .tx_done       (tx_done)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  int cyc = 0, frames = 0, starts = 0, gap = 0, end_cyc = -1000;
  int last_done = 0, prev_done = 0;
  bit mon_act = 1'b0;
  int mon_cnt = 0;
  logic [9:0] mon_frame = '0;

  typedef struct {
    logic [7:0] d;
    logic [9:0] frame;  // line bits in time order, bit 0 = start bit
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Holds valid until the byte is taken; one handshake per call.
  task automatic send_hold(input logic [7:0] d);
    uart_tx_valid = 1'b1;
    uart_tx_data  = d;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (uart_tx_ready) begin
        @(posedge sys_clk);
        #1;
        uart_tx_valid = 1'b0;
        return;
      end
    end
    uart_tx_valid = 1'b0;
    check("hold_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!uart_tx_busy && exp_q.size() == 0 && !mon_act) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("wait_idle", ok, 1);
  endtask

  // Receiver model, scoreboard push and cycle counter, all on the falling edge.
  initial forever begin
    @(negedge sys_clk);
    cyc++;
    if (tx_done) begin
      prev_done = last_done;
      last_done = cyc;
    end
    if (!sys_rst_n && uart_tx_valid && uart_tx_ready) exp_q.push_back(uart_tx_data);
    if (sys_rst_n) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (!uart_txd) begin
        mon_act = 1'b1;
        mon_cnt = 0;
        gap     = cyc - end_cyc;
        starts++;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % 10 == 5) mon_frame[mon_cnt / 10] = uart_txd;
      if (mon_cnt == 99) begin
        mon_act = 1'b0;
        end_cyc = cyc;
        frames++;
        check("rx_start_bit", mon_frame[0], 0);
        check("rx_stop_bit", mon_frame[9], 1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got byte %0d want none", mon_frame[8:1]);
        end else begin
          check("rx_byte", mon_frame[8:1], exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn, dn, done_at, f0, s0, lows;
    bit found;
    logic [9:0] cap;

    vecs[0] = '{d: 8'h55, frame: 10'b1_01010101_0};
    vecs[1] = '{d: 8'h00, frame: 10'b1_00000000_0};
    vecs[2] = '{d: 8'hFF, frame: 10'b1_11111111_0};
    vecs[3] = '{d: 8'h5A, frame: 10'b1_01011010_0};
    vecs[4] = '{d: 8'hA5, frame: 10'b1_10100101_0};

    // Reset values
    repeat (3) tick();
    check("rst_txd", uart_txd, 1);
    check("rst_ready", uart_tx_ready, 1);
    check("rst_busy", uart_tx_busy, 0);
    check("rst_done", tx_done, 0);
    sys_rst_n = 1'b0;
    tick();

    // Single frames from idle, with latency and frame-length checks
    foreach (vecs[v]) begin
      uart_tx_valid = 1'b1;
      uart_tx_data  = vecs[v].d;
      tick();  // handshake edge N
      uart_tx_valid = 1'b0;
      uart_tx_data  = 8'hXX;
      check("lat_ready_low", uart_tx_ready, 0);
      check("lat_txd_idle", uart_txd, 1);
      tick();  // edge N+1: START
      check("lat_txd_start", uart_txd, 0);
      check("lat_ready_high", uart_tx_ready, 1);
      bn = 0;
      dn = 0;
      done_at = -1;
      cap = '0;
      for (int k = 0; k < 100; k++) begin
        if (uart_tx_busy) bn++;
        if (tx_done) begin
          dn++;
          done_at = k;
        end
        if (k % 10 == 5) cap[k / 10] = uart_txd;
        tick();
      end
      check("vec_frame", cap, vecs[v].frame);
      check("vec_busy_len", bn, 100);
      check("vec_done_cnt", dn, 1);
      check("vec_done_pos", done_at, 99);
      check("vec_end_busy", uart_tx_busy, 0);
      check("vec_end_txd", uart_txd, 1);
    end
    wait_idle();

    // Back-to-back: no gap, tx_done pulses 100 clocks apart
    send_hold(8'hA5);
    send_hold(8'h3C);
    check("b2b_ready_full", uart_tx_ready, 0);
    wait_idle();
    check("b2b_gap", gap, 1);
    check("b2b_done_spacing", last_done - prev_done, 100);

    // Backpressure: three held bytes, each sent once and in order
    f0 = frames;
    send_hold(8'h01);
    send_hold(8'h02);
    send_hold(8'h03);
    wait_idle();
    check("bp_frames", frames - f0, 3);

    // Acceptance in the final stop cycle leaves one idle clock
    send_hold(8'h81);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx_done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("fc_done_seen", found, 1);
    uart_tx_valid = 1'b1;
    uart_tx_data  = 8'hFF;
    tick();
    uart_tx_valid = 1'b0;
    check("fc_idle_txd", uart_txd, 1);
    check("fc_idle_busy", uart_tx_busy, 0);
    check("fc_idle_ready", uart_tx_ready, 0);
    tick();
    check("fc_start_txd", uart_txd, 0);
    check("fc_start_busy", uart_tx_busy, 1);
    wait_idle();
    check("fc_gap", gap, 2);

    // Asynchronous reset mid-DATA with a byte buffered
    send_hold(8'h11);
    send_hold(8'h22);
    repeat (30) tick();
    check("ar_pre_ready", uart_tx_ready, 0);
    check("ar_pre_busy", uart_tx_busy, 1);
    #2;
    sys_rst_n = 1'b1;
    #1;
    check("ar_txd", uart_txd, 1);
    check("ar_ready", uart_tx_ready, 1);
    check("ar_busy", uart_tx_busy, 0);
    exp_q.delete();
    s0 = starts;
    repeat (3) tick();
    sys_rst_n = 1'b0;
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (!uart_txd) lows++;
    end
    check("ar_no_frame", starts - s0, 0);
    check("ar_line_high", lows, 0);

    // Line still works after reset
    send_hold(8'hC3);
    wait_idle();

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
